// File: rtl/tx_char_fifo.sv
// Character FIFO between the serial mode controller and the UART transmitter.
// It drains over valid/ready with a selectable inter-character gap. Define WR_EDGE_EN to make writes trigger on the rising edge of wr_en.
module tx_char_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int GAP0  = 0,
  parameter int GAP1  = 8,
  parameter int GAP2  = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          clean,
  input  logic          start_en,
  input  logic [1:0]    rate_sel,
  input  logic          tx_ready,
  output logic          tx_valid,
  output logic [7:0]    tx_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          overflow
);

  localparam int GW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [GW-1:0] gapCnt;
  logic          wrReq;
  logic          push;
  logic          pop;
  logic [AW:0]   countNext;

  function automatic logic [GW-1:0] gapFor(input logic [1:0] sel);
    logic [GW-1:0] g;
    case (sel)
      2'd1:    g = GW'(GAP1);
      2'd2:    g = GW'(GAP2);
      default: g = GW'(GAP0);
    endcase
    return g;
  endfunction

`ifdef WR_EDGE_EN
  logic wrEnQ;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wrEnQ <= 1'b0;
    else        wrEnQ <= wr_en;
  end

  assign wrReq = wr_en & ~wrEnQ;
`else
  assign wrReq = wr_en;
`endif

  // A pop frees a slot in the same edge, so a write to a full FIFO still lands when a pop coincides.
  assign pop  = (state == SEND) & tx_valid & tx_ready & ~clean;
  assign push = wrReq & (~full | pop) & ~clean;

  always_comb begin
    countNext = count;
    case ({push, pop})
      2'b10:   countNext = count + 1'b1;
      2'b01:   countNext = count - 1'b1;
      default: countNext = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      gapCnt   <= '0;
      state    <= IDLE;
    end else if (clean) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
      tx_valid <= 1'b0;
      gapCnt   <= '0;
      state    <= IDLE;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      count <= countNext;
      full  <= (countNext == (AW+1)'(DEPTH));
      empty <= (countNext == '0);
      if (wrReq && full && !pop) overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (start_en && !empty) begin
            tx_data  <= mem[rdPtr];
            tx_valid <= 1'b1;
            state    <= SEND;
          end
        end
        // The presented character stays put until accepted, regardless of start_en.
        SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if (gapFor(rate_sel) == '0) begin
              state <= IDLE;
            end else begin
              gapCnt <= gapFor(rate_sel);
              state  <= GAP;
            end
          end
        end
        GAP: begin
          if (gapCnt <= GW'(1)) begin
            gapCnt <= '0;
            state  <= IDLE;
          end else begin
            gapCnt <= gapCnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_char_fifo.sv
// Directed self-checking bench for tx_char_fifo; one task per scenario.
module tb_tx_char_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       clean;
  logic       start_en;
  logic [1:0] rate_sel;
  logic       tx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       overflow;

  int checks = 0;
  int failures = 0;

  tx_char_fifo #(.DEPTH(16), .AW(4), .GAP0(0), .GAP1(8), .GAP2(32)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .clean(clean),
    .start_en(start_en), .rate_sel(rate_sel), .tx_ready(tx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .count(count), .full(full),
    .empty(empty), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; wr_en = 1'b0; wr_data = 8'h00; clean = 1'b0;
    start_en = 1'b0; rate_sel = 2'd0; tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();
  endtask

  // Single-cycle pulse so the write also counts under edge-triggered mode.
  task automatic write_char(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    start_en = 1'b1;
    write_char(8'h5A);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h5A) begin
      failures++;
      $display("FAIL pre_reset_present valid=%b data=%h want 1/5a", tx_valid, tx_data);
    end
    #3 reset = 1'b0;
    #1;
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0 ||
        tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      failures++;
      $display("FAIL async_reset count=%0d empty=%b full=%b ovf=%b valid=%b data=%h want 0/1/0/0/0/00",
               count, empty, full, overflow, tx_valid, tx_data);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    start_en = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] expData [3];
    expData[0] = 8'h41; expData[1] = 8'h42; expData[2] = 8'h43;
    do_reset();
    tx_ready = 1'b1;
    write_char(8'h41); write_char(8'h42); write_char(8'h43);
    checks++;
    if (count !== 5'd3 || tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_queued count=%0d valid=%b want 3/0", count, tx_valid);
    end
    start_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== expData[i]) begin
        failures++;
        $display("FAIL b2b_char%0d valid=%b data=%h want 1/%h", i, tx_valid, tx_data, expData[i]);
      end
      tick();
      checks++;
      if (tx_valid !== 1'b0) begin
        failures++;
        $display("FAIL b2b_reload%0d valid=%b want 0", i, tx_valid);
      end
    end
    checks++;
    if (empty !== 1'b1 || count !== 5'd0) begin
      failures++;
      $display("FAIL b2b_empty empty=%b count=%0d want 1/0", empty, count);
    end
  endtask

  task automatic test_gap();
    int first = 0, second = 0, nvalid = 0;
    logic [7:0] d0 = 8'h00, d1 = 8'h00;
    do_reset();
    rate_sel = 2'd1; tx_ready = 1'b1;
    write_char(8'h10); write_char(8'h11);
    start_en = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (tx_valid) begin
        nvalid++;
        if (first == 0) begin first = t; d0 = tx_data; end
        else if (second == 0) begin second = t; d1 = tx_data; end
      end
    end
    checks++;
    if (first !== 1 || nvalid !== 2) begin
      failures++;
      $display("FAIL gap_first first=%0d nvalid=%0d want 1/2", first, nvalid);
    end
    checks++;
    if (second - first !== 10) begin
      failures++;
      $display("FAIL gap_spacing got=%0d want 10", second - first);
    end
    checks++;
    if (d0 !== 8'h10 || d1 !== 8'h11) begin
      failures++;
      $display("FAIL gap_data got=%h,%h want 10,11", d0, d1);
    end
  endtask

  task automatic test_overflow();
    int nrx = 0;
    logic [7:0] e;
    do_reset();
    for (int i = 0; i < 17; i++) write_char(8'(8'h60 + i));
    checks++;
    if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_state full=%b count=%0d ovf=%b want 1/16/1", full, count, overflow);
    end
    tx_ready = 1'b1; start_en = 1'b1;
    for (int t = 0; t < 80; t++) begin
      tick();
      if (tx_valid) begin
        e = 8'(8'h60 + nrx);
        checks++;
        if (tx_data !== e) begin
          failures++;
          $display("FAIL ovf_drain%0d data=%h want %h", nrx, tx_data, e);
        end
        nrx++;
      end
    end
    checks++;
    if (nrx !== 16 || empty !== 1'b1 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_total n=%0d empty=%b ovf=%b want 16/1/1", nrx, empty, overflow);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    write_char(8'h70); write_char(8'h71);
    start_en = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) start_en = 1'b0;
      tick();
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h70 || count !== 5'd2) begin
        failures++;
        $display("FAIL bp_hold%0d valid=%b data=%h count=%0d want 1/70/2", i, tx_valid, tx_data, count);
      end
    end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    checks++;
    if (tx_valid !== 1'b0 || count !== 5'd1) begin
      failures++;
      $display("FAIL bp_pop valid=%b count=%0d want 0/1", tx_valid, count);
    end
    repeat (3) tick();
    checks++;
    if (tx_valid !== 1'b0 || count !== 5'd1) begin
      failures++;
      $display("FAIL bp_single valid=%b count=%0d want 0/1", tx_valid, count);
    end
  endtask

  task automatic test_clean();
    int t = 0;
    do_reset();
    for (int i = 0; i < 17; i++) write_char(8'(8'h80 + i));
    tx_ready = 1'b1; start_en = 1'b1;
    while (!(count == 5'd4 && tx_valid) && t < 80) begin
      tick();
      t++;
    end
    checks++;
    if (count !== 5'd4 || tx_valid !== 1'b1 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL clean_setup count=%0d valid=%b ovf=%b want 4/1/1", count, tx_valid, overflow);
    end
    clean = 1'b1; wr_en = 1'b1; wr_data = 8'hAA;
    tick();
    clean = 1'b0; wr_en = 1'b0;
    checks++;
    if (tx_valid !== 1'b0 || count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL clean_flush valid=%b count=%0d empty=%b ovf=%b want 0/0/1/0",
               tx_valid, count, empty, overflow);
    end
    tick();
    checks++;
    if (count !== 5'd0 || tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL clean_discard count=%0d valid=%b want 0/0", count, tx_valid);
    end
    wr_en = 1'b1; wr_data = 8'hBB;
    tick();
    wr_en = 1'b0;
    tick();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hBB) begin
      failures++;
      $display("FAIL clean_restart valid=%b data=%h want 1/bb", tx_valid, tx_data);
    end
  endtask

  task automatic test_wr_level();
    logic [4:0] expCount;
`ifdef WR_EDGE_EN
    expCount = 5'd1;
`else
    expCount = 5'd4;
`endif
    do_reset();
    wr_en = 1'b1; wr_data = 8'h35;
    repeat (4) tick();
    wr_en = 1'b0;
    tick();
    checks++;
    if (count !== expCount) begin
      failures++;
      $display("FAIL wr_hold count=%0d want %0d", count, expCount);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gap();
    test_overflow();
    test_backpressure();
    test_clean();
    test_wr_level();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_char_fifo.md
Name: tx_char_fifo

Overview:
- Downstream stage of the serial mode controller.
- Buffers the 8-bit characters it emits through its write-enable/data pair into a circular FIFO.
- Drains the FIFO to the UART transmitter over a valid/ready handshake while the controller grants transmission (start gate).
- Inserts a rate-dependent idle gap between characters; the controller's clean pulse flushes the buffer.

Parameters:
- DEPTH, 16: FIFO entries; power of two, ≥4.
- AW, 4: pointer width; log2(DEPTH).
- GAP0, 0: idle cycles after each character when rate_sel=0.
- GAP1, 8: idle cycles after each character when rate_sel=1.
- GAP2, 32: idle cycles after each character when rate_sel=2 (rate_sel=3 uses GAP0).

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- wr_en  in  1  write request from mode controller
- wr_data  in  8  character to store
- clean  in  1  synchronous flush request
- start_en  in  1  transmission grant; 1 = draining allowed
- rate_sel  in  2  gap selector
- tx_ready  in  1  UART transmitter can accept a character
- tx_valid  out  1  tx_data holds a valid character
- tx_data  out  8  character to transmit
- count  out  AW+1  current occupancy, 0..DEPTH
- full  out  1  count==DEPTH
- empty  out  1  count==0
- overflow  out  1  sticky: a write was dropped

Behaviour:
- Reset (async, reset=0): pointers=0, count=0, empty=1, full=0, overflow=0, tx_valid=0, tx_data=0, gap counter=0, state=IDLE. Memory contents undefined.
- Write: on a clk edge with wr_en=1 and full=0, store wr_data at wr_ptr, wr_ptr+1 (wraps DEPTH-1→0), count+1.
- Write while full=1 (and no pop that cycle): data dropped, overflow←1; overflow stays set until clean or reset.
- Pop: occurs on a clk edge with tx_valid=1 and tx_ready=1; rd_ptr+1 with wrap, count-1.
- Simultaneous write and pop: both succeed and count is unchanged. When full, a write in the same cycle as a pop is accepted.
- count, full and empty are registered and reflect the post-edge state.
- FSM IDLE:
  - If start_en=1 and empty=0: tx_data←mem[rd_ptr], tx_valid←1, go SEND.
  - Otherwise stay in IDLE.
  - Earliest latency: write at edge N; tx_valid=1 after edge N+1.
- FSM SEND:
  - tx_valid and tx_data are held stable until tx_ready=1; start_en falling does not withdraw a presented character.
  - On handshake: pop, tx_valid←0, sample rate_sel → gap G.
  - If G=0, go IDLE; otherwise load gap counter with G and go GAP.
- FSM GAP:
  - Counter decrements each cycle; exit to IDLE on the edge where it reaches 0.
  - GAP lasts exactly G cycles; rate_sel changes during GAP are ignored.
- Clean:
  - Synchronous and highest priority: pointers=0, count=0, overflow=0, tx_valid=0, gap counter=0, state=IDLE.
  - A write in the same cycle as clean is discarded.
  - A character being presented is aborted and not popped, even if tx_ready=1 that cycle.
- Back-to-back with G=0: a new character is presented one cycle after each handshake (IDLE reload cycle), i.e. at most one character per 2 cycles.
- count never exceeds DEPTH and never underflows; a pop is impossible when empty.

Optional Feature:
- Macro WR_EDGE_EN.
- Defined: a write occurs only on the rising edge of wr_en, detected against a registered copy of wr_en that resets to 0. A wr_en held high for k cycles writes once, using wr_data from the first cycle.
- Undefined: a write occurs on every cycle wr_en=1 (level-sensitive), as described above.

Test Plan:
- Reset then write 0x41,0x42,0x43 with start_en=0 → count=3, tx_valid=0. Raise start_en with tx_ready=1, rate_sel=0 → tx_data 0x41,0x42,0x43 in order, one per 2 cycles, then empty=1.
- rate_sel=1 (GAP1=8), two characters queued, tx_ready=1 → exactly 8 idle cycles plus 1 reload cycle between handshakes.
- Write 17 characters with start_en=0, DEPTH=16 → full=1, count=16, overflow=1. Drain all → the first 16 characters are output and the 17th is absent.
- tx_ready=0 while tx_valid=1 for 5 cycles, start_en dropped mid-way → tx_data stable, no pop. tx_ready=1 → single pop.
- clean pulse while in SEND with count=4 and overflow=1 → next cycle: tx_valid=0, count=0, empty=1, overflow=0, state IDLE. A write during the clean cycle is not stored.
- Under WR_EDGE_EN, hold wr_en high for 4 cycles with data 0x35 → count=1. Without the macro → count=4.
